// File: rtl/alu_rs_scheduler.sv
// ALU reservation-station scheduler.
// Holds up to ENTRIES dispatched instructions, wakes their operands from the
// common data bus, and issues one ready instruction per cycle to the ALU
// using round-robin selection.
module alu_rs_scheduler #(
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        disp_valid,
    input  logic [4:0]  disp_op,
    input  logic [31:0] disp_vj,
    input  logic [31:0] disp_vk,
    input  logic [2:0]  disp_qj,
    input  logic [2:0]  disp_qk,
    input  logic [2:0]  disp_dest,
    input  logic        cdb_valid,
    input  logic [2:0]  cdb_tag,
    input  logic [31:0] cdb_value,
    output logic        disp_ready,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_value_1,
    output logic [31:0] alu_value_2,
    output logic [2:0]  alu_des,
    output logic [3:0]  occupancy
);

    localparam int IDXW = $clog2(ENTRIES);

    // Per-slot storage
    logic [ENTRIES-1:0] busy;
    logic [4:0]         slot_op   [ENTRIES];
    logic [31:0]        slot_vj   [ENTRIES];
    logic [31:0]        slot_vk   [ENTRIES];
    logic [2:0]         slot_qj   [ENTRIES];
    logic [2:0]         slot_qk   [ENTRIES];
    logic [2:0]         slot_dest [ENTRIES];
    logic [IDXW-1:0]    rr_ptr;

    // Scheduling decisions for the current cycle
    logic [ENTRIES-1:0] eligible;
    logic               issue_valid;
    logic [IDXW-1:0]    issue_idx;
    logic [IDXW-1:0]    cand;
    logic               free_found;
    logic [IDXW-1:0]    free_idx;
    logic               accept;
    logic [ENTRIES-1:0] busy_next;
    logic [3:0]         occ_next;

    // Dispatch operands after same-cycle CDB bypass
    logic [31:0]        disp_vj_eff;
    logic [31:0]        disp_vk_eff;
    logic [2:0]         disp_qj_eff;
    logic [2:0]         disp_qk_eff;

    // A slot can issue only once both of its registered tags are clear
    always_comb begin
        eligible = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            eligible[i] = busy[i] && (slot_qj[i] == 3'd0) && (slot_qk[i] == 3'd0);
        end
    end

    // Round-robin pick: first eligible slot at or after rr_ptr, wrapping
    always_comb begin
        issue_valid = 1'b0;
        issue_idx   = '0;
        cand        = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            cand = rr_ptr + IDXW'(k);
            if (!issue_valid && eligible[cand]) begin
                issue_valid = 1'b1;
                issue_idx   = cand;
            end
        end
    end

    // Lowest-index free slot, judged only on registered busy bits so a slot
    // vacated by this cycle's issue is not handed out until next cycle
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!free_found && !busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
        end
    end

    assign disp_ready = free_found;
    assign accept     = disp_valid && free_found && !flush;

    // Capture a result broadcast in the same cycle the dependent instruction dispatches
    always_comb begin
        disp_vj_eff = disp_vj;
        disp_qj_eff = disp_qj;
        disp_vk_eff = disp_vk;
        disp_qk_eff = disp_qk;
        if (cdb_valid && (disp_qj != 3'd0) && (disp_qj == cdb_tag)) begin
            disp_vj_eff = cdb_value;
            disp_qj_eff = 3'd0;
        end
        if (cdb_valid && (disp_qk != 3'd0) && (disp_qk == cdb_tag)) begin
            disp_vk_eff = cdb_value;
            disp_qk_eff = 3'd0;
        end
    end

    // Busy bits and occupancy after this edge when neither reset nor flush applies
    always_comb begin
        busy_next = busy;
        if (issue_valid) begin
            busy_next[issue_idx] = 1'b0;
        end
        if (accept) begin
            busy_next[free_idx] = 1'b1;
        end
        occ_next = 4'd0;
        for (int i = 0; i < ENTRIES; i++) begin
            occ_next = occ_next + {3'b000, busy_next[i]};
        end
    end

    // Control state and registered ALU issue port
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            rr_ptr      <= '0;
            occupancy   <= 4'd0;
            alu_op      <= 5'd0;
            alu_value_1 <= 32'd0;
            alu_value_2 <= 32'd0;
            alu_des     <= 3'd0;
        end else if (flush) begin
            busy        <= '0;
            occupancy   <= 4'd0;
            alu_op      <= 5'd0;
            alu_value_1 <= 32'd0;
            alu_value_2 <= 32'd0;
            alu_des     <= 3'd0;
        end else begin
            busy      <= busy_next;
            occupancy <= occ_next;
            if (issue_valid) begin
                rr_ptr      <= issue_idx + 1'b1;
                alu_op      <= slot_op[issue_idx];
                alu_value_1 <= slot_vj[issue_idx];
                alu_value_2 <= slot_vk[issue_idx];
                alu_des     <= slot_dest[issue_idx];
            end else begin
                alu_op      <= 5'd0;
                alu_value_1 <= 32'd0;
                alu_value_2 <= 32'd0;
                alu_des     <= 3'd0;
            end
        end
    end

    // Slot payload: new dispatch into the chosen slot, CDB wakeup for waiting slots
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (accept && (free_idx == IDXW'(i))) begin
                    slot_op[i]   <= disp_op;
                    slot_vj[i]   <= disp_vj_eff;
                    slot_vk[i]   <= disp_vk_eff;
                    slot_qj[i]   <= disp_qj_eff;
                    slot_qk[i]   <= disp_qk_eff;
                    slot_dest[i] <= disp_dest;
                end else if (busy[i] && cdb_valid) begin
                    if ((slot_qj[i] != 3'd0) && (slot_qj[i] == cdb_tag)) begin
                        slot_vj[i] <= cdb_value;
                        slot_qj[i] <= 3'd0;
                    end
                    if ((slot_qk[i] != 3'd0) && (slot_qk[i] == cdb_tag)) begin
                        slot_vk[i] <= cdb_value;
                        slot_qk[i] <= 3'd0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: hand-derived vector table for the
// directed scenarios, then randomized traffic against a behavioural model.
module tb_alu_rs_scheduler;

    localparam int E = 4;

    logic        clk = 1'b0;
    logic        rst, flush, disp_valid, cdb_valid;
    logic [4:0]  disp_op;
    logic [31:0] disp_vj, disp_vk, cdb_value;
    logic [2:0]  disp_qj, disp_qk, disp_dest, cdb_tag;
    logic        disp_ready;
    logic [4:0]  alu_op;
    logic [31:0] alu_value_1, alu_value_2;
    logic [2:0]  alu_des;
    logic [3:0]  occupancy;

    alu_rs_scheduler #(.ENTRIES(E)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_dest(disp_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .disp_ready(disp_ready), .alu_op(alu_op),
        .alu_value_1(alu_value_1), .alu_value_2(alu_value_2),
        .alu_des(alu_des), .occupancy(occupancy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        dv;
        logic [4:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [2:0]  qj;
        logic [2:0]  qk;
        logic [2:0]  dest;
        logic        cv;
        logic [2:0]  ctag;
        logic [31:0] cval;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        erdy;
        logic [4:0]  eop;
        logic [31:0] ev1;
        logic [31:0] ev2;
        logic [2:0]  edes;
        logic [3:0]  eocc;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    stim_t cur;
    vec_t  tbl[$];

    // Reference model: a bag of slots evolved by the scheduling rules
    bit          m_busy [E];
    logic [4:0]  m_op   [E];
    logic [31:0] m_vj   [E];
    logic [31:0] m_vk   [E];
    logic [2:0]  m_qj   [E];
    logic [2:0]  m_qk   [E];
    logic [2:0]  m_dest [E];
    int          m_rr = 0;
    logic [4:0]  m_aop = 0;
    logic [31:0] m_a1 = 0;
    logic [31:0] m_a2 = 0;
    logic [2:0]  m_ades = 0;
    int          m_occ = 0;

    function automatic stim_t idleS();
        stim_t s;
        s.rst = 0; s.flush = 0; s.dv = 0; s.op = 0; s.vj = 0; s.vk = 0;
        s.qj = 0; s.qk = 0; s.dest = 0; s.cv = 0; s.ctag = 0; s.cval = 0;
        return s;
    endfunction

    function automatic stim_t rstS();
        stim_t s = idleS();
        s.rst = 1;
        return s;
    endfunction

    function automatic stim_t dispS(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                    input logic [2:0] qj, input logic [2:0] qk, input logic [2:0] dest);
        stim_t s = idleS();
        s.dv = 1; s.op = op; s.vj = vj; s.vk = vk; s.qj = qj; s.qk = qk; s.dest = dest;
        return s;
    endfunction

    function automatic stim_t cdbS(input logic [2:0] tag, input logic [31:0] val);
        stim_t s = idleS();
        s.cv = 1; s.ctag = tag; s.cval = val;
        return s;
    endfunction

    task automatic addRow(input stim_t s, input logic erdy, input logic [4:0] eop, input logic [31:0] ev1,
                          input logic [31:0] ev2, input logic [2:0] edes, input logic [3:0] eocc);
        vec_t v;
        v.s = s; v.erdy = erdy; v.eop = eop; v.ev1 = ev1; v.ev2 = ev2; v.edes = edes; v.eocc = eocc;
        tbl.push_back(v);
    endtask

    function automatic logic modelReady();
        int cnt = 0;
        for (int i = 0; i < E; i++) cnt += m_busy[i] ? 1 : 0;
        return cnt < E;
    endfunction

    // Advance the model by one clock edge
    task automatic modelStep(input stim_t s);
        int pick;
        int freeSlot;
        int idx;
        if (s.rst) begin
            for (int i = 0; i < E; i++) m_busy[i] = 0;
            m_rr = 0;
            m_aop = 0; m_a1 = 0; m_a2 = 0; m_ades = 0;
        end else if (s.flush) begin
            for (int i = 0; i < E; i++) m_busy[i] = 0;
            m_aop = 0; m_a1 = 0; m_a2 = 0; m_ades = 0;
        end else begin
            pick = -1;
            for (int k = 0; k < E; k++) begin
                idx = (m_rr + k) % E;
                if (pick < 0 && m_busy[idx] && m_qj[idx] == 0 && m_qk[idx] == 0) pick = idx;
            end
            freeSlot = -1;
            for (int i = E - 1; i >= 0; i--) if (!m_busy[i]) freeSlot = i;
            if (pick >= 0) begin
                m_aop = m_op[pick]; m_a1 = m_vj[pick]; m_a2 = m_vk[pick]; m_ades = m_dest[pick];
            end else begin
                m_aop = 0; m_a1 = 0; m_a2 = 0; m_ades = 0;
            end
            if (s.cv && s.ctag != 0) begin
                for (int i = 0; i < E; i++) begin
                    if (m_busy[i] && m_qj[i] == s.ctag) begin m_vj[i] = s.cval; m_qj[i] = 0; end
                    if (m_busy[i] && m_qk[i] == s.ctag) begin m_vk[i] = s.cval; m_qk[i] = 0; end
                end
            end
            if (pick >= 0) begin
                m_busy[pick] = 0;
                m_rr = (pick + 1) % E;
            end
            if (s.dv && freeSlot >= 0) begin
                m_busy[freeSlot] = 1;
                m_op[freeSlot]   = s.op;
                m_dest[freeSlot] = s.dest;
                m_vj[freeSlot]   = (s.cv && s.qj != 0 && s.qj == s.ctag) ? s.cval : s.vj;
                m_qj[freeSlot]   = (s.cv && s.qj != 0 && s.qj == s.ctag) ? 3'd0 : s.qj;
                m_vk[freeSlot]   = (s.cv && s.qk != 0 && s.qk == s.ctag) ? s.cval : s.vk;
                m_qk[freeSlot]   = (s.cv && s.qk != 0 && s.qk == s.ctag) ? 3'd0 : s.qk;
            end
        end
        m_occ = 0;
        for (int i = 0; i < E; i++) m_occ += m_busy[i] ? 1 : 0;
    endtask

    // Drive one cycle's inputs just after the falling edge
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        cur        = s;
        rst        = s.rst;
        flush      = s.flush;
        disp_valid = s.dv;
        disp_op    = s.op;
        disp_vj    = s.vj;
        disp_vk    = s.vk;
        disp_qj    = s.qj;
        disp_qk    = s.qk;
        disp_dest  = s.dest;
        cdb_valid  = s.cv;
        cdb_tag    = s.ctag;
        cdb_value  = s.cval;
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelStep(cur);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic stim_t randStim();
        stim_t s = idleS();
        s.rst   = ($urandom_range(0, 199) == 0);
        s.flush = ($urandom_range(0, 39) == 0);
        s.dv    = ($urandom_range(0, 9) < 6);
        s.op    = 5'($urandom);
        s.vj    = $urandom;
        s.vk    = $urandom;
        s.qj    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 4));
        s.qk    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 4));
        s.dest  = 3'($urandom_range(1, 7));
        s.cv    = ($urandom_range(0, 9) < 5);
        s.ctag  = 3'($urandom_range(0, 5));
        s.cval  = $urandom;
        return s;
    endfunction

    // Main test sequence
    initial begin
        stim_t t;

        // Directed vector table
        addRow(rstS(), 1, 0, 0, 0, 0, 0);
        addRow(dispS(0, 5, 7, 0, 0, 3), 1, 0, 0, 0, 0, 1);
        addRow(idleS(), 1, 0, 5, 7, 3, 0);
        addRow(idleS(), 1, 0, 0, 0, 0, 0);
        addRow(dispS(1, 0, 32'h22, 2, 0, 5), 1, 0, 0, 0, 0, 1);
        addRow(idleS(), 1, 0, 0, 0, 0, 1);
        addRow(cdbS(2, 32'h10), 1, 0, 0, 0, 0, 1);
        addRow(idleS(), 1, 1, 32'h10, 32'h22, 5, 0);
        t = dispS(2, 32'h33, 0, 0, 4, 6); t.cv = 1; t.ctag = 4; t.cval = 9;
        addRow(t, 1, 0, 0, 0, 0, 1);
        addRow(idleS(), 1, 2, 32'h33, 9, 6, 0);
        addRow(rstS(), 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            addRow(dispS(5'(3 + i), 32'h100 + i, 32'h200 + i, 1, 0, 3'(i + 1)), 1, 0, 0, 0, 0, 4'(i + 1));
        end
        addRow(dispS(7, 1, 2, 0, 0, 7), 0, 0, 0, 0, 0, 4);
        addRow(cdbS(1, 32'hABC), 0, 0, 0, 0, 0, 4);
        addRow(dispS(15, 3, 4, 0, 0, 7), 0, 3, 32'hABC, 32'h200, 1, 3);
        addRow(idleS(), 1, 4, 32'hABC, 32'h201, 2, 2);
        addRow(idleS(), 1, 5, 32'hABC, 32'h202, 3, 1);
        addRow(idleS(), 1, 6, 32'hABC, 32'h203, 4, 0);
        addRow(idleS(), 1, 0, 0, 0, 0, 0);
        addRow(dispS(8, 32'h11, 32'h12, 0, 0, 1), 1, 0, 0, 0, 0, 1);
        addRow(dispS(9, 0, 32'h22, 5, 0, 2), 1, 8, 32'h11, 32'h12, 1, 1);
        addRow(dispS(10, 0, 32'h23, 6, 0, 3), 1, 0, 0, 0, 0, 2);
        addRow(dispS(11, 0, 32'h24, 6, 0, 4), 1, 0, 0, 0, 0, 3);
        addRow(cdbS(6, 32'h66), 1, 0, 0, 0, 0, 3);
        addRow(idleS(), 1, 11, 32'h66, 32'h24, 4, 2);
        addRow(idleS(), 1, 10, 32'h66, 32'h23, 3, 1);
        addRow(dispS(12, 0, 0, 7, 0, 5), 1, 0, 0, 0, 0, 2);
        addRow(dispS(13, 0, 0, 7, 0, 6), 1, 0, 0, 0, 0, 3);
        t = dispS(14, 1, 1, 0, 0, 7); t.flush = 1; t.cv = 1; t.ctag = 5; t.cval = 1;
        addRow(t, 1, 0, 0, 0, 0, 0);
        addRow(idleS(), 1, 0, 0, 0, 0, 0);
        addRow(cdbS(5, 1), 1, 0, 0, 0, 0, 0);
        addRow(idleS(), 1, 0, 0, 0, 0, 0);
        addRow(dispS(16, 32'hAA, 32'hBB, 0, 0, 2), 1, 0, 0, 0, 0, 1);
        t = dispS(17, 1, 1, 0, 0, 3); t.rst = 1;
        addRow(t, 1, 0, 0, 0, 0, 0);
        addRow(idleS(), 1, 0, 0, 0, 0, 0);
        t = dispS(18, 0, 0, 3, 3, 4); t.cv = 1; t.ctag = 3; t.cval = 32'h5A5A5A5A;
        addRow(t, 1, 0, 0, 0, 0, 1);
        addRow(idleS(), 1, 18, 32'h5A5A5A5A, 32'h5A5A5A5A, 4, 0);
        addRow(dispS(19, 0, 0, 2, 2, 5), 1, 0, 0, 0, 0, 1);
        addRow(cdbS(2, 32'h99), 1, 0, 0, 0, 0, 1);
        addRow(idleS(), 1, 19, 32'h99, 32'h99, 5, 0);

        // Initial reset, not checked
        for (int i = 0; i < 2; i++) begin
            applyStimulus(rstS());
            clockEdge();
        end

        foreach (tbl[r]) begin
            applyStimulus(tbl[r].s);
            checkOutput($sformatf("row%0d disp_ready", r), {31'd0, disp_ready}, {31'd0, tbl[r].erdy});
            clockEdge();
            checkOutput($sformatf("row%0d alu_op", r), {27'd0, alu_op}, {27'd0, tbl[r].eop});
            checkOutput($sformatf("row%0d alu_value_1", r), alu_value_1, tbl[r].ev1);
            checkOutput($sformatf("row%0d alu_value_2", r), alu_value_2, tbl[r].ev2);
            checkOutput($sformatf("row%0d alu_des", r), {29'd0, alu_des}, {29'd0, tbl[r].edes});
            checkOutput($sformatf("row%0d occupancy", r), {28'd0, occupancy}, {28'd0, tbl[r].eocc});
        end

        // Randomized traffic against the model
        applyStimulus(rstS());
        clockEdge();
        for (int c = 0; c < 4000; c++) begin
            applyStimulus(randStim());
            checkOutput($sformatf("rand%0d disp_ready", c), {31'd0, disp_ready}, {31'd0, modelReady()});
            clockEdge();
            checkOutput($sformatf("rand%0d alu_op", c), {27'd0, alu_op}, {27'd0, m_aop});
            checkOutput($sformatf("rand%0d alu_value_1", c), alu_value_1, m_a1);
            checkOutput($sformatf("rand%0d alu_value_2", c), alu_value_2, m_a2);
            checkOutput($sformatf("rand%0d alu_des", c), {29'd0, alu_des}, {29'd0, m_ades});
            checkOutput($sformatf("rand%0d occupancy", c), {28'd0, occupancy}, 32'(m_occ));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
